pll_reset_sequencer: RTL

- Sequences the system PLL after power-up and on lock loss.
- Pulses the PLL reset, waits for `locked` with a timeout, and filters `locked` for stability.
- Holds the downstream core reset until the clocks are trustworthy.
- Retries a bounded number of times, then raises a sticky fault. Sits between the PLL wrapper and the core reset tree, clocked from the 50 MHz reference.

---
 rtl/pll_ctrl_pkg.sv | 61 ++++++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types, defaults and helpers for the PLL reset sequencer.
package pll_ctrl_pkg;

    // Sequencer states; 3-bit encoding, two codes unused.
    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pll_state_e;

    // Default timing for a 50 MHz reference.
    localparam int DEF_RESET_CYCLES   = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65536;
    localparam int DEF_LOCK_FILTER    = 1024;
    localparam int DEF_RELEASE_CYCLES = 256;
    localparam int DEF_MAX_RETRIES    = 3;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // Registered output bundle, decoded from the state.
    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic ready;
        logic fault;
    } pll_out_t;

    // One shared timer must reach the largest terminal count (N-1), so
    // clog2 of the largest count is enough; never narrower than 1 bit.
    function automatic int timer_width(input int a, input int b,
                                       input int c, input int d);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

    // Output levels per state; unknown codes fall back to the reset levels.
    function automatic pll_out_t decode_outputs(input pll_state_e s);
        pll_out_t o;
        case (s)
            ST_ASSERT:    o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            ST_WAIT_LOCK: o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            ST_FILTER:    o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            ST_RELEASE:   o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
            ST_RUN:       o = '{pll_rst: 1'b0, sys_rst: 1'b0, ready: 1'b1, fault: 1'b0};
            ST_FAULT:     o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b1};
            default:      o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static signals crossing into i_clk.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First flop may go metastable; second flop gives it a cycle to settle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a filtered lock,
// then releases the core reset; bounded retries end in a sticky fault.
module pll_reset_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  loss_cnt
);

    localparam int TMR_W = timer_width(RESET_CYCLES, LOCK_TIMEOUT,
                                       LOCK_FILTER, RELEASE_CYCLES);

    // Terminal counts; every phase counts 0..N-1 and compares for equality.
    localparam logic [TMR_W-1:0]   RESET_TC   = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TIMEOUT_TC = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   FILTER_TC  = TMR_W'(LOCK_FILTER - 1);
    localparam logic [TMR_W-1:0]   RELEASE_TC = TMR_W'(RELEASE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_MAX   = '1;

    pll_state_e         r_state;
    pll_state_e         w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [LOSS_W-1:0]  r_loss;
    logic [LOSS_W-1:0]  w_loss_nxt;
    pll_out_t           r_out;
    logic               w_attempt_fail;
    logic               w_lk;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk (refclk),
        .i_rst (rst),
        .i_d   (pll_locked),
        .o_q   (w_lk)
    );

    // Next-state, timer and counter logic for the sequencing FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_retry_nxt    = r_retry;
        w_loss_nxt     = r_loss;
        w_attempt_fail = 1'b0;

        case (r_state)
            ST_ASSERT: begin
                if (r_timer == RESET_TC) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end

            // A lock seen on the timeout cycle still wins.
            ST_WAIT_LOCK: begin
                if (w_lk) begin
                    w_state_nxt = ST_FILTER;
                    w_timer_nxt = '0;
                end else if (r_timer == TIMEOUT_TC) begin
                    w_attempt_fail = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end

            // Any drop restarts the lock wait without consuming a retry.
            ST_FILTER: begin
                if (!w_lk) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else if (r_timer == FILTER_TC) begin
                    w_state_nxt = ST_RELEASE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end

            // A drop this late means the lock was not trustworthy: retry.
            ST_RELEASE: begin
                if (!w_lk) begin
                    w_attempt_fail = 1'b1;
                end else if (r_timer == RELEASE_TC) begin
                    w_state_nxt = ST_RUN;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end

            // A lock loss starts a fresh sequence with a fresh retry budget.
            ST_RUN: begin
                if (!w_lk) begin
                    if (r_loss != LOSS_MAX) begin
                        w_loss_nxt = r_loss + LOSS_W'(1);
                    end
                    w_retry_nxt = '0;
                    w_state_nxt = ST_ASSERT;
                    w_timer_nxt = '0;
                end else if (relock_req) begin
                    w_retry_nxt = '0;
                    w_state_nxt = ST_ASSERT;
                    w_timer_nxt = '0;
                end
            end

            ST_FAULT: begin
                if (relock_req) begin
                    w_retry_nxt = '0;
                    w_state_nxt = ST_ASSERT;
                    w_timer_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_ASSERT;
                w_timer_nxt = '0;
            end
        endcase

        // Failed attempt: either spend a retry or give up for good.
        if (w_attempt_fail) begin
            w_timer_nxt = '0;
            if (r_retry == RETRY_MAX) begin
                w_state_nxt = ST_FAULT;
            end else begin
                w_retry_nxt = r_retry + RETRY_W'(1);
                w_state_nxt = ST_ASSERT;
            end
        end
    end

    // State, timer and counter registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= ST_ASSERT;
            r_timer <= '0;
            r_retry <= '0;
            r_loss  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_retry <= w_retry_nxt;
            r_loss  <= w_loss_nxt;
        end
    end

    // Outputs registered from the next state so they align with r_state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_out <= decode_outputs(ST_ASSERT);
        end else begin
            r_out <= decode_outputs(w_state_nxt);
        end
    end

    assign pll_rst   = r_out.pll_rst;
    assign sys_rst   = r_out.sys_rst;
    assign ready     = r_out.ready;
    assign fault     = r_out.fault;
    assign retry_cnt = r_retry;
    assign loss_cnt  = r_loss;

endmodule
